id_pipe: RTL and testbench

Parametrised RV32I decode stage with a registered, elastic output. Sits between fetch and execute. Accepts instruction/PC pairs over a valid/ready handshake and decodes register fields, opcode, funct3/funct7 and the immediate for every base format (I/S/B/U/J). Results are buffered in a small FIFO so fetch can run ahead while execute stalls.

---
 rtl/id_pkg.sv | 66 ++++++
 rtl/imm_gen.sv | 54 +++++
 rtl/id_pipe.sv | 128 ++++++++++++
 tb/tb_id_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// id_pkg: shared definitions for the id_pipe decode stage.
//   - RV32I opcode constants
//   - imm_type_e: immediate format reported alongside each decode
//   - dec_rec_t: XLEN-independent part of a buffered decode record
//   - is_illegal(): opcode/funct legality (only with ID_ILLEGAL_CHK_EN)
package id_pkg;

    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;
    localparam logic [6:0] MISC_MEM = 7'b0001111;

    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_type_e;

    // pc and imm are XLEN wide and kept in separate arrays beside this record.
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [2:0] imm_type;
`ifdef ID_ILLEGAL_CHK_EN
        logic       illegal;
`endif
    } dec_rec_t;

`ifdef ID_ILLEGAL_CHK_EN
    // funct7 only carries an opcode extension for OP and for the OP-IMM shifts;
    // for other OP-IMM forms those bits are immediate and never illegal.
    function automatic logic is_illegal(input logic [31:0] inst);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       bad_funct;
        op = inst[6:0];
        f3 = inst[14:12];
        f7 = inst[31:25];
        bad_funct = (f7 != 7'b0000000 && f7 != 7'b0100000) ||
                    (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101);
        case (op)
            OP:     return bad_funct;
            OP_IMM: return (f3 == 3'b001 || f3 == 3'b101) ? bad_funct : 1'b0;
            LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, MISC_MEM:
                    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction
`endif

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32I immediate decoder.
// Ports:
//   inst      in   32    raw instruction
//   imm       out  XLEN  sign-extended immediate (0 for R/unknown formats)
//   imm_type  out  3     format: R=0 I=1 S=2 B=3 U=4 J=5
module imm_gen
    import id_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      imm_type
);

    logic [31:0] imm32;
    imm_type_e   fmt;

    always_comb begin
        imm32 = '0;
        fmt   = IMM_R;
        case (inst[6:0])
            OP_IMM, LOAD, JALR, SYSTEM: begin
                fmt   = IMM_I;
                imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            STORE: begin
                fmt   = IMM_S;
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            BRANCH: begin
                fmt   = IMM_B;
                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            LUI, AUIPC: begin
                fmt   = IMM_U;
                imm32 = {inst[31:12], 12'b0};
            end
            JAL: begin
                fmt   = IMM_J;
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: begin
                fmt   = IMM_R;
                imm32 = '0;
            end
        endcase
    end

    // Signed size cast widens to XLEN with sign extension.
    assign imm      = XLEN'($signed(imm32));
    assign imm_type = fmt;

endmodule

// File: rtl/id_pipe.sv
// id_pipe: RV32I decode stage with a DEPTH-entry elastic output FIFO.
// Optional feature macro: ID_ILLEGAL_CHK_EN (per-entry illegal-instruction flag;
// when undefined, illegal is tied to 0 and not stored).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous discard of all buffered entries
//   in_valid/in_ready   fetch handshake carrying inst (32) and pc (XLEN)
//   out_valid/out_ready execute handshake for the head entry
//   out_pc, rs1, rs2, rd, opcode, funct3, funct7, imm, imm_type, illegal
//                       decoded fields of the head entry
module id_pipe
    import id_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      imm_type,
    output logic            illegal
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    dec_rec_t        rec_mem [DEPTH];
    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [XLEN-1:0] imm_mem [DEPTH];

    dec_rec_t        in_rec;
    dec_rec_t        head;
    logic [XLEN-1:0] in_imm;
    logic [2:0]      in_imm_type;
    logic            push;
    logic            pop;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst     (inst),
        .imm      (in_imm),
        .imm_type (in_imm_type)
    );

    always_comb begin
        in_rec          = '0;
        in_rec.rs1      = inst[19:15];
        in_rec.rs2      = inst[24:20];
        in_rec.rd       = inst[11:7];
        in_rec.opcode   = inst[6:0];
        in_rec.funct3   = inst[14:12];
        in_rec.funct7   = inst[31:25];
        in_rec.imm_type = in_imm_type;
`ifdef ID_ILLEGAL_CHK_EN
        in_rec.illegal  = is_illegal(inst);
`endif
    end

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rec_mem <= '{default: '0};
            pc_mem  <= '{default: '0};
            imm_mem <= '{default: '0};
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                rec_mem[wr_ptr] <= in_rec;
                pc_mem[wr_ptr]  <= pc;
                imm_mem[wr_ptr] <= in_imm;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head     = rec_mem[rd_ptr];
    assign out_pc   = pc_mem[rd_ptr];
    assign imm      = imm_mem[rd_ptr];
    assign rs1      = head.rs1;
    assign rs2      = head.rs2;
    assign rd       = head.rd;
    assign opcode   = head.opcode;
    assign funct3   = head.funct3;
    assign funct7   = head.funct7;
    assign imm_type = head.imm_type;
`ifdef ID_ILLEGAL_CHK_EN
    assign illegal  = head.illegal;
`else
    assign illegal  = 1'b0;
`endif

endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: directed-vector bench for id_pipe with a queue-based reference
// model checked every cycle, plus literal expectations for key vectors.
module tb_id_pipe;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [31:0]     inst = '0;
    logic [XLEN-1:0] pc = '0;
    logic            in_ready, out_valid, illegal;
    logic [XLEN-1:0] out_pc, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3, imm_type;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
    } ent_t;
    ent_t mq[$];

    id_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rs1(rs1), .rs2(rs2), .rd(rd), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .imm(imm), .imm_type(imm_type), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the ISA immediate layouts.
    function automatic int m_type(input logic [31:0] i);
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: return 1;
            7'h23: return 2;
            7'h63: return 3;
            7'h37, 7'h17: return 4;
            7'h6F: return 5;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] i);
        logic signed [31:0] s;
        s = $signed(i);
        case (m_type(i))
            1: return 32'(s >>> 20);
            2: return (32'(s >>> 20) & ~32'h1F) | {27'b0, i[11:7]};
            3: return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            4: return i & 32'hFFFFF000;
            5: return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_illegal(input logic [31:0] i);
`ifdef ID_ILLEGAL_CHK_EN
        logic bad;
        bad = !(i[31:25] == 7'h00 || (i[31:25] == 7'h20 && (i[14:12] == 3'd0 || i[14:12] == 3'd5)));
        if (i[6:0] == 7'h33) return bad;
        if (i[6:0] == 7'h13) return (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? bad : 1'b0;
        case (i[6:0])
            7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0F: return 1'b0;
            default: return 1'b1;
        endcase
`else
        return i[0] & 1'b0;
`endif
    endfunction

    // Model occupancy update, mirroring the handshake rules at each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else begin : upd
            bit m_pop, m_push;
            ent_t e;
            m_pop  = (mq.size() != 0) && out_ready;
            m_push = in_valid && (mq.size() != DEPTH);
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                e.inst = inst;
                e.pc   = pc;
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin : cmp
            ent_t e;
            chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
            chk("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
            if (mq.size() != 0) begin
                e = mq[0];
                chk("out_pc", 64'(out_pc), 64'(e.pc));
                chk("rs1", 64'(rs1), 64'(e.inst[19:15]));
                chk("rs2", 64'(rs2), 64'(e.inst[24:20]));
                chk("rd", 64'(rd), 64'(e.inst[11:7]));
                chk("opcode", 64'(opcode), 64'(e.inst[6:0]));
                chk("funct3", 64'(funct3), 64'(e.inst[14:12]));
                chk("funct7", 64'(funct7), 64'(e.inst[31:25]));
                chk("imm", 64'(imm), 64'(m_imm(e.inst)));
                chk("imm_type", 64'(imm_type), 64'(m_type(e.inst)));
                chk("illegal", 64'(illegal), 64'(m_illegal(e.inst)));
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] i, input logic [XLEN-1:0] p,
                        input logic ordy, input logic fl);
        in_valid  = v;
        inst      = i;
        pc        = p;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_data"}, 64'({out_pc, rs1, rs2, rd, opcode, funct3, funct7}), 64'd0);
        chk({tag, "_imm"}, 64'(imm), 64'd0);
        chk({tag, "_imm_type"}, 64'(imm_type), 64'd0);
        chk({tag, "_illegal"}, 64'(illegal), 64'd0);
    endtask

    logic [31:0] tbl [10] = '{32'h40315233, 32'h0082A183, 32'hFF818067, 32'h00000073,
                              32'h00001517, 32'h0000100F, 32'h02A5C5B3, 32'h80000537,
                              32'hFFF00013, 32'h00209463};

    initial begin
        #2;
        chk_zero_outputs("reset");
        #10 rst_n = 1'b1;

        // Single decode, then back-to-back with out_ready high.
        step(1'b1, 32'hFFF10093, 32'h100, 1'b1, 1'b0);
        chk("addi_rd", 64'(rd), 64'd1);
        chk("addi_rs1", 64'(rs1), 64'd2);
        chk("addi_imm", 64'(imm), 64'hFFFFFFFF);
        chk("addi_type", 64'(imm_type), 64'd1);
        chk("addi_valid", 64'(out_valid), 64'd1);
        step(1'b1, 32'h00112623, 32'h104, 1'b1, 1'b0);
        chk("sw_imm", 64'(imm), 64'd12);
        chk("sw_type", 64'(imm_type), 64'd2);
        step(1'b1, 32'hFE000EE3, 32'h108, 1'b1, 1'b0);
        chk("beq_imm", 64'(imm), 64'hFFFFFFFC);
        chk("beq_type", 64'(imm_type), 64'd3);
        step(1'b1, 32'h123452B7, 32'h10C, 1'b1, 1'b0);
        chk("lui_rd", 64'(rd), 64'd5);
        chk("lui_imm", 64'(imm), 64'h12345000);
        chk("lui_type", 64'(imm_type), 64'd4);
        step(1'b1, 32'h001000EF, 32'h110, 1'b1, 1'b0);
        chk("jal_rd", 64'(rd), 64'd1);
        chk("jal_imm", 64'(imm), 64'h00000800);
        chk("jal_type", 64'(imm_type), 64'd5);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("drained", 64'(out_valid), 64'd0);

        // Backpressure: fill, then release with a held push.
        step(1'b1, 32'h00000013, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'h00100093, 32'h204, 1'b0, 1'b0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_head_pc", 64'(out_pc), 64'h200);
        step(1'b1, 32'h00200113, 32'h208, 1'b1, 1'b0);
        chk("bp_head_pc1", 64'(out_pc), 64'h204);
        step(1'b1, 32'h00200113, 32'h208, 1'b1, 1'b0);
        chk("bp_head_pc2", 64'(out_pc), 64'h208);
        step(1'b1, 32'h00300193, 32'h20C, 1'b1, 1'b0);
        chk("bp_head_pc3", 64'(out_pc), 64'h20C);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with two buffered entries and a push offered in the same cycle.
        step(1'b1, 32'h00400213, 32'h300, 1'b0, 1'b0);
        step(1'b1, 32'h00500293, 32'h304, 1'b0, 1'b0);
        step(1'b1, 32'h00600313, 32'h308, 1'b1, 1'b1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("flush_no_ghost", 64'(out_valid), 64'd0);

        // Mixed formats with a stall pattern on out_ready.
        begin : table_run
            int k;
            int cyc;
            logic acc;
            k = 0;
            cyc = 0;
            while (k < 10 && cyc < 100) begin
                in_valid  = 1'b1;
                inst      = tbl[k];
                pc        = XLEN'(32'h400 + 4 * k);
                out_ready = (cyc % 3) != 1;
                flush     = 1'b0;
                acc       = in_ready;
                @(posedge clk);
                #1;
                if (acc) k++;
                cyc++;
            end
            chk("table_progress", 64'(k), 64'd10);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Unknown opcode.
        step(1'b1, 32'h0000007F, 32'h500, 1'b1, 1'b0);
`ifdef ID_ILLEGAL_CHK_EN
        chk("ill_flag", 64'(illegal), 64'd1);
`else
        chk("ill_flag", 64'(illegal), 64'd0);
`endif
        chk("ill_imm", 64'(imm), 64'd0);
        chk("ill_type", 64'(imm_type), 64'd0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges while full.
        step(1'b1, 32'hABCDE0B7, 32'h600, 1'b0, 1'b0);
        step(1'b1, 32'hFFF10093, 32'h604, 1'b0, 1'b0);
        chk("pre_rst_full", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_zero_outputs("async_rst");
        #3 rst_n = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h00112623, 32'h700, 1'b1, 1'b0);
        chk("post_rst_imm", 64'(imm), 64'd12);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
